adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
//  Trigger-based capture sequencer for the 4-channel ADC monitor stream (ad_a0/a1/b0/b1 + ad_strobe).
//  Keeps a pre-trigger ring of samples, captures post-trigger samples until the buffer is full,
//  then drains the frame {b1,b0,a1,a0} oldest-first over a valid/ready port. Sits beside the launch
//  state machine; trigger = S_FIRE entry, arm = S_CHARGE entry.
// PARAMETERS
//  DEPTH        1024  buffer entries; power of 2, >=8
//  AW           10    log2(DEPTH)
//  PRE_SAMPLES  256   target pre-trigger samples; 1..DEPTH-1
//  DECIM        1     store every DECIM-th strobe; 1..255
// PORTS
//  clk         in   1   system clock (48 MHz)
//  reset       in   1   one clock; reset is synchronous and active-high
//  ad_a0/a1/b0/b1 in 12 ADC hold values, valid when ad_strobe
//  ad_strobe   in   1   1-cycle new-sample pulse
//  arm         in   1   pulse: start capture (honoured only in IDLE)
//  trigger     in   1   level; rising edge marks trigger
//  abort       in   1   pulse: return to IDLE from any state
//  rd_ready    in   1   consumer accepts rd_data
//  rd_valid    out  1   rd_data valid
//  rd_data     out  48  {b1,b0,a1,a0}
//  rd_last     out  1   final word of frame, qualified by rd_valid
//  busy        out  1   state != IDLE
//  cap_state   out  3   cap_state_t encoding
//  trig_index  out  AW  buffer address of trigger sample
// BEHAVIOUR
//  Reset/abort: next cycle state=IDLE, rd_valid=0, rd_last=0, rd_data=0, trig_index=0, pointers/counters=0.
//   Reset: all outputs zero; abort: buffer contents are don't-care.
//  Store event: ad_strobe && dec_cnt==0 in FILL/WAIT/POST; dec_cnt reloads DECIM-1, else decrements on strobe.
//   dec_cnt=0 on arm. Strobes ignored in IDLE/READ.
//  Write: entry wr_ptr <= sample; wr_ptr+1 mod DEPTH (wraps DEPTH-1 -> 0).
//  Trigger edge = trigger && !trigger_q; trigger_q registered every cycle.
//  States:
//   IDLE -> FILL on arm; wr_ptr=0, pre_cnt=0.
//   FILL: each store increments pre_cnt; pre_cnt reaches PRE_SAMPLES -> WAIT.
//   WAIT: ring writes, pre_cnt held at PRE_SAMPLES.
//   FILL/WAIT -> POST on trigger edge; an edge in FILL leaves pre_cnt short (frame still DEPTH).
//   POST: first store on/after edge cycle = trigger sample; trig_index <= its wr_ptr.
//    Same-cycle edge+store: that sample. Stores continue until post_cnt == DEPTH-pre_cnt -> READ.
//   READ: rd_ptr = trig_index-pre_cnt mod DEPTH; words emitted in address order, DEPTH total.
//    RAM read latency 1; first rd_valid 2 cycles after READ entry.
//    rd_valid/rd_data/rd_last held stable while rd_valid && !rd_ready.
//    Back-to-back accept sustains 1 word/cycle via 1-entry skid.
//    Accept with rd_last -> IDLE next cycle, rd_valid=0.
//  arm outside IDLE ignored; trigger edges in POST/READ ignored; abort wins over all same-cycle events.
//  Edge during FILL on first-ever store cycle: pre_cnt=0, trigger sample at address 0.
// STRUCTURE
//  Package adc_capture_pkg: cap_state_t enum (IDLE=0,FILL=1,WAIT=2,POST=3,READ=4);
//   adc_frame_t packed struct {b1,b0,a1,a0}; FRAME_W=48.
//  Sub-module capture_ram: simple dual-port RAM, DEPTH x 48, 1 write port, 1 registered read port
//   (1-cycle latency), no reset; infers block RAM.
//  Top: FSM, decimator, pointers, trigger edge detect, read skid register.
// TESTING (bench: DEPTH=16, PRE_SAMPLES=4, DECIM=1, strobe every 16 clks, sample n = {4{12'(n)}})
//  1 arm, trigger edge after sample 9, rd_ready=1 -> trig_index=10; 16 words = samples 6..21;
//    rd_last on word 16 (sample 21); then IDLE.
//  2 trigger edge after 2nd store in FILL -> pre_cnt=2; frame = samples 0..15; trig_index=2.
//  3 rd_ready toggled 1/0 per cycle in READ -> rd_data stable while stalled;
//    exactly 16 accepts, none dropped/duplicated.
//  4 DECIM=3 -> only strobes 0,3,6,... stored; frame values step by 3.
//  5 abort mid-POST, then arm -> busy 1->0 next cycle; rd_valid never asserts;
//    new capture matches scenario 1 ordering.
//  6 reset asserted mid-READ with rd_valid=1 -> next cycle rd_valid=0, cap_state=0;
//    arm held high through READ -> no effect.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types for the ADC trigger-capture sequencer: state encoding and the
// 48-bit frame word layout {b1,b0,a1,a0}.
package adc_capture_pkg;

   localparam int FRAME_W = 48;

   typedef enum logic [2:0] {
      CAP_IDLE = 3'd0,
      CAP_FILL = 3'd1,
      CAP_WAIT = 3'd2,
      CAP_POST = 3'd3,
      CAP_READ = 3'd4
   } cap_state_t;

   typedef struct packed {
      logic [11:0] b1;
      logic [11:0] b0;
      logic [11:0] a1;
      logic [11:0] a0;
   } adc_frame_t;

   function automatic adc_frame_t pack_frame(input logic [11:0] a0,
                                             input logic [11:0] a1,
                                             input logic [11:0] b0,
                                             input logic [11:0] b1);
      adc_frame_t f;
      f.b1 = b1;
      f.b0 = b0;
      f.a1 = a1;
      f.a0 = a0;
      return f;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port
// (1-cycle latency). No reset so it maps onto block RAM.
module capture_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int W     = 48
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Trigger-based capture sequencer: pre-trigger ring, post-trigger fill, then
// oldest-first drain of DEPTH frame words over a valid/ready port.
module adc_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int AW          = 10,
   parameter int PRE_SAMPLES = 256,
   parameter int DECIM       = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [11:0]        ad_a0,
   input  logic [11:0]        ad_a1,
   input  logic [11:0]        ad_b0,
   input  logic [11:0]        ad_b1,
   input  logic               ad_strobe,
   input  logic               arm,
   input  logic               trigger,
   input  logic               abort,
   input  logic               rd_ready,
   output logic               rd_valid,
   output logic [FRAME_W-1:0] rd_data,
   output logic               rd_last,
   output logic               busy,
   output logic [2:0]         cap_state,
   output logic [AW-1:0]      trig_index
);

   localparam logic [2:0] ST_IDLE = CAP_IDLE;
   localparam logic [2:0] ST_FILL = CAP_FILL;
   localparam logic [2:0] ST_WAIT = CAP_WAIT;
   localparam logic [2:0] ST_POST = CAP_POST;
   localparam logic [2:0] ST_READ = CAP_READ;

   localparam int          DEC_M1     = DECIM - 1;
   localparam logic [7:0]  DEC_RELOAD = DEC_M1[7:0];
   localparam logic [AW:0] DEPTH_C    = DEPTH[AW:0];
   localparam logic [AW:0] LAST_C     = DEPTH_C - 1'b1;
   localparam logic [AW:0] PRE_C      = PRE_SAMPLES[AW:0];

   // Read port handshake: a word transfers on any clk edge where rd_valid and
   // rd_ready are both high; while rd_valid && !rd_ready, rd_valid, rd_data
   // and rd_last hold their values until the transfer happens.

   logic [2:0]         state;
   logic [7:0]         dec_cnt;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        pre_cnt;
   logic [AW:0]        post_cnt;
   logic [AW:0]        rd_cnt;
   logic               trig_seen;
   logic               trigger_q;

   logic               ram_vld;
   logic               ram_last;
   logic [FRAME_W-1:0] ram_q;
   logic               skid_vld;
   logic               skid_last;
   logic [FRAME_W-1:0] skid_data;

   logic               in_capture;
   logic               trig_edge;
   logic               go_post;
   logic               store;
   logic               post_store;
   logic               pre_fill;
   logic               post_done;
   logic [AW:0]        post_cnt_inc;
   logic [AW:0]        pre_cnt_inc;
   logic [AW-1:0]      trig_next;
   logic               accept;
   logic [1:0]         occ;
   logic [1:0]         occ_after;
   logic               issue;
   logic [FRAME_W-1:0] wr_word;

   always_comb begin
      in_capture   = (state == ST_FILL) || (state == ST_WAIT) || (state == ST_POST);
      trig_edge    = trigger && !trigger_q;
      go_post      = ((state == ST_FILL) || (state == ST_WAIT)) && trig_edge;
      store        = in_capture && ad_strobe && (dec_cnt == 8'd0);
      // A store coinciding with the trigger edge is the trigger sample itself.
      post_store   = store && ((state == ST_POST) || go_post);
      pre_fill     = store && (state == ST_FILL) && !go_post;
      post_cnt_inc = post_cnt + 1'b1;
      pre_cnt_inc  = pre_cnt + 1'b1;
      post_done    = post_store && (post_cnt_inc == (DEPTH_C - pre_cnt));
      trig_next    = (post_store && !trig_seen) ? wr_ptr : trig_index;
      accept       = rd_valid && rd_ready;
      occ          = {1'b0, rd_valid} + {1'b0, skid_vld} + {1'b0, ram_vld};
      occ_after    = occ - {1'b0, accept};
      // At most two words committed (output + skid), counting the one in the RAM.
      issue        = (state == ST_READ) && (rd_cnt != DEPTH_C) && (occ_after < 2'd2);
      wr_word      = pack_frame(ad_a0, ad_a1, ad_b0, ad_b1);
   end

   capture_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (FRAME_W)
   ) u_ram (
      .clk   (clk),
      .we    (store),
      .waddr (wr_ptr),
      .wdata (wr_word),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         trigger_q <= 1'b0;
      end else begin
         trigger_q <= trigger;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || abort) begin
         state      <= ST_IDLE;
         dec_cnt    <= 8'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         rd_cnt     <= '0;
         trig_seen  <= 1'b0;
         trig_index <= '0;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (in_capture && ad_strobe) begin
            dec_cnt <= (dec_cnt == 8'd0) ? DEC_RELOAD : dec_cnt - 8'd1;
         end
         if (pre_fill) begin
            pre_cnt <= pre_cnt_inc;
         end
         if (post_store) begin
            post_cnt   <= post_cnt_inc;
            trig_seen  <= 1'b1;
            trig_index <= trig_next;
         end
         if (issue) begin
            rd_ptr <= rd_ptr + 1'b1;
            rd_cnt <= rd_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (arm) begin
                  state     <= ST_FILL;
                  wr_ptr    <= '0;
                  pre_cnt   <= '0;
                  post_cnt  <= '0;
                  dec_cnt   <= 8'd0;
                  trig_seen <= 1'b0;
                  rd_cnt    <= '0;
               end
            end
            ST_FILL: begin
               if (go_post) begin
                  state <= post_done ? ST_READ : ST_POST;
               end else if (pre_fill && (pre_cnt_inc == PRE_C)) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (go_post) begin
                  state <= post_done ? ST_READ : ST_POST;
               end
            end
            ST_POST: begin
               if (post_done) begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               if (accept && rd_last) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // Frame starts pre_cnt entries before the trigger sample, wrapping.
         if (post_done) begin
            rd_ptr <= trig_next - pre_cnt[AW-1:0];
            rd_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || abort) begin
         ram_vld   <= 1'b0;
         ram_last  <= 1'b0;
         skid_vld  <= 1'b0;
         skid_last <= 1'b0;
         skid_data <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
      end else begin
         ram_vld  <= issue;
         ram_last <= issue && (rd_cnt == LAST_C);
         if (!rd_valid || accept) begin
            if (skid_vld) begin
               rd_valid  <= 1'b1;
               rd_data   <= skid_data;
               rd_last   <= skid_last;
               skid_vld  <= ram_vld;
               skid_data <= ram_q;
               skid_last <= ram_last;
            end else if (ram_vld) begin
               rd_valid <= 1'b1;
               rd_data  <= ram_q;
               rd_last  <= ram_last;
            end else begin
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
            end
         end else if (ram_vld) begin
            skid_vld  <= 1'b1;
            skid_data <= ram_q;
            skid_last <= ram_last;
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign cap_state = state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized bench for adc_capture_ctrl: a sample-history model predicts each
// frame, trigger address and end-of-frame behaviour for DECIM=1 and DECIM=3.
module tb_adc_capture_ctrl;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int PRE   = 4;

   logic        clk;
   logic        reset;
   logic [11:0] ad_a0, ad_a1, ad_b0, ad_b1;
   logic        ad_strobe, arm, trigger, abort, rd_ready;

   logic          v1, l1, bz1, v3, l3, bz3;
   logic [47:0]   d1, d3;
   logic [2:0]    s1, s3;
   logic [AW-1:0] t1, t3;

   int sel;
   logic          m_valid, m_last, m_busy;
   logic [47:0]   m_data;
   logic [2:0]    m_state;
   logic [AW-1:0] m_trig;

   assign m_valid = (sel == 1) ? v3  : v1;
   assign m_last  = (sel == 1) ? l3  : l1;
   assign m_busy  = (sel == 1) ? bz3 : bz1;
   assign m_data  = (sel == 1) ? d3  : d1;
   assign m_state = (sel == 1) ? s3  : s1;
   assign m_trig  = (sel == 1) ? t3  : t1;

   adc_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .PRE_SAMPLES(PRE), .DECIM(1)) dut (
      .clk(clk), .reset(reset), .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1),
      .ad_strobe(ad_strobe), .arm(arm), .trigger(trigger), .abort(abort), .rd_ready(rd_ready),
      .rd_valid(v1), .rd_data(d1), .rd_last(l1), .busy(bz1), .cap_state(s1), .trig_index(t1));

   adc_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .PRE_SAMPLES(PRE), .DECIM(3)) dut3 (
      .clk(clk), .reset(reset), .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1),
      .ad_strobe(ad_strobe), .arm(arm), .trigger(trigger), .abort(abort), .rd_ready(rd_ready),
      .rd_valid(v3), .rd_data(d3), .rd_last(l3), .busy(bz3), .cap_state(s3), .trig_index(t3));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard and model state
   logic [48:0] exp_q[$];
   logic [47:0] hist[$];
   int n_checks, n_pass;
   int sidx, trig_pos, decim, ready_mode, valid_cycles;
   bit trig_pending, last_seen;
   logic [AW-1:0] exp_trig;
   bit          prev_stall;
   logic [47:0] prev_data;
   logic        prev_last;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   initial begin
      rd_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = !rd_ready;
            2:       rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin : monitor
      logic [48:0] e;
      if (m_valid) valid_cycles++;
      if (prev_stall) begin
         check("stall_valid", m_valid, 1);
         check("stall_data", m_data, prev_data);
         check("stall_last", m_last, prev_last);
      end
      if (m_valid && rd_ready) begin
         check("word_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rd_data", m_data, e[47:0]);
            check("rd_last", m_last, e[48]);
            if (m_last) last_seen = 1;
         end
      end
      prev_stall = !reset && m_valid && !rd_ready;
      prev_data  = m_data;
      prev_last  = m_last;
   end

   // driver tasks
   task automatic do_strobe(input bit with_trig);
      logic [47:0] v;
      v = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
      @(posedge clk); #1;
      {ad_b1, ad_b0, ad_a1, ad_a0} = v;
      ad_strobe = 1'b1;
      if (with_trig) begin
         trigger = 1'b1;
         trig_pending = 1;
      end
      if (sidx % decim == 0) begin
         hist.push_back(v);
         if (trig_pending && trig_pos < 0) trig_pos = hist.size() - 1;
      end
      sidx++;
      @(posedge clk); #1;
      ad_strobe = 1'b0;
      trigger   = 1'b0;
   endtask

   task automatic pulse_abort();
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
   endtask

   task automatic wait_frame();
      for (int k = 0; k < 3000 && !last_seen; k++) @(negedge clk);
      check("frame_done", last_seen, 1);
      @(negedge clk);
      check("words_left", exp_q.size(), 0);
      check("end_state", m_state, 0);
      check("end_valid", m_valid, 0);
      check("end_busy", m_busy, 0);
      check("trig_index", m_trig, exp_trig);
      if (!last_seen) begin
         exp_q.delete();
         pulse_abort();
      end
   endtask

   // fin: 0 drain frame, 1 abort after abort_after post stores, 2 stall in READ then reset
   task automatic run_capture(input int n_before, input bit same, input int rmode,
                              input int fin, input int abort_after);
      int pre;
      pre = 0;
      hist.delete();
      sidx = 0; trig_pos = -1; trig_pending = 0; last_seen = 0; valid_cycles = 0;
      ready_mode = rmode;
      @(posedge clk); #1; arm = 1'b1;
      @(posedge clk); #1; arm = 1'b0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 200; k++) begin
         if (k == n_before && !same) begin
            @(posedge clk); #1;
            trigger = 1'b1;
            trig_pending = 1;
            repeat (2) @(posedge clk);
         end
         do_strobe(k == n_before && same);
         if (trig_pos >= 0) begin
            pre = (trig_pos < PRE) ? trig_pos : PRE;
            if (fin == 1 && hist.size() - trig_pos == abort_after) break;
            if (hist.size() - trig_pos == DEPTH - pre) break;
         end
         repeat ($urandom_range(2, 14)) @(posedge clk);
      end
      if (fin == 1) begin
         check("busy_pre_abort", m_busy, 1);
         pulse_abort();
         @(negedge clk);
         check("abort_busy", m_busy, 0);
         check("abort_state", m_state, 0);
         check("abort_trig", m_trig, 0);
         check("abort_valid", m_valid, 0);
         check("abort_no_valid", valid_cycles, 0);
      end else begin
         for (int k = 0; k < DEPTH; k++)
            exp_q.push_back({(k == DEPTH - 1), hist[trig_pos - pre + k]});
         exp_trig = AW'(trig_pos % DEPTH);
         if (fin == 0) begin
            wait_frame();
         end else begin
            for (int k = 0; k < 50 && !m_valid; k++) @(negedge clk);
            check("stall_first_valid", m_valid, 1);
            @(posedge clk); #1; arm = 1'b1;
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("arm_in_read_state", m_state, 4);
            check("arm_in_read_data", m_data, exp_q[0][47:0]);
            @(posedge clk); #1; reset = 1'b1; arm = 1'b0;
            @(posedge clk); #1; reset = 1'b0;
            @(negedge clk);
            check("rst_valid", m_valid, 0);
            check("rst_state", m_state, 0);
            check("rst_data", m_data, 0);
            check("rst_last", m_last, 0);
            check("rst_trig", m_trig, 0);
            check("rst_busy", m_busy, 0);
            exp_q.delete();
         end
      end
   endtask

   initial begin
      n_checks = 0; n_pass = 0; sel = 0; decim = 1; ready_mode = 0;
      reset = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0; ad_strobe = 1'b0;
      ad_a0 = '0; ad_a1 = '0; ad_b0 = '0; ad_b1 = '0;
      prev_stall = 0; last_seen = 0; valid_cycles = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_valid", v1, 0);
      check("reset_last", l1, 0);
      check("reset_data", d1, 0);
      check("reset_busy", bz1, 0);
      check("reset_state", s1, 0);
      check("reset_trig", t1, 0);
      check("reset_state_d3", s3, 0);
      check("reset_valid_d3", v3, 0);

      run_capture(10, 0, 0, 0, 0);
      run_capture(2, 0, 0, 0, 0);
      run_capture(9, 0, 1, 0, 0);
      run_capture(0, 1, 2, 0, 0);
      for (int i = 0; i < 3; i++)
         run_capture($urandom_range(0, 24), 1'($urandom_range(0, 1)), 2, 0, 0);
      run_capture(6, 0, 0, 1, 3);
      run_capture(10, 0, 0, 0, 0);
      run_capture($urandom_range(3, 12), 0, 3, 2, 0);

      sel = 1; decim = 3;
      pulse_abort();
      run_capture(7, 0, 0, 0, 0);
      run_capture($urandom_range(0, 20), 1'($urandom_range(0, 1)), 2, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
